// File: rtl/mii_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mii_pkg
// Brief    : Shared state encoding and constants for the MII RX deframer.
// Revision : 1.0 - initial release
// ============================================================================
package mii_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;

    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

endpackage
`default_nettype wire

// File: rtl/mii_crc32_byte.sv
`default_nettype none
// ============================================================================
// Module   : mii_crc32_byte
// Brief    : Combinational reflected CRC-32 update by one byte (LSB first).
// Revision : 1.0 - initial release
// ============================================================================
module mii_crc32_byte
    import mii_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_acc;

    always_comb begin
        w_acc = i_crc ^ {24'h000000, i_data};
        for (int b = 0; b < 8; b++) begin
            w_acc = w_acc[0] ? ((w_acc >> 1) ^ CRC_POLY) : (w_acc >> 1);
        end
        o_crc = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/mii_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : mii_rx_deframer
// Brief    : MII RX nibble deframer - strips preamble/SFD, rebuilds bytes
//            low-nibble-first, marks last byte, length and frame errors.
//            Define MII_RX_FCS_CHECK_EN to add the CRC-32 FCS check.
// Revision : 1.0 - initial release
// ============================================================================
module mii_rx_deframer
    import mii_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int LEN_W           = 16
)(
    input  logic             phy_rx_clk,
    input  logic             phy_rst,
    input  logic [3:0]       phy_rxd,
    input  logic             phy_rx_dv,
    input  logic             phy_rx_er,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic             m_err,
    output logic [LEN_W-1:0] frame_len,
    output logic             stat_frame_good,
    output logic             stat_frame_bad,
    output logic             stat_preamble_err
);

    localparam logic [LEN_W-1:0] c_max_cnt = LEN_W'(MAX_FRAME_BYTES);

    state_t           r_state, w_state;
    logic             r_dv_prev;
    logic             r_phase, w_phase;
    logic [3:0]       r_low_nib, w_low_nib;
    logic [7:0]       r_hold_data, w_hold_data;
    logic             r_hold_valid, w_hold_valid;
    logic [LEN_W-1:0] r_byte_cnt, w_byte_cnt;
    logic             r_err, w_err;

    logic [7:0]       w_byte;
    logic [7:0]       w_m_data;
    logic             w_m_valid, w_m_last, w_m_err;
    logic [LEN_W-1:0] w_frame_len;
    logic             w_good, w_bad, w_pre_err;
    logic             w_crc_bad;

    assign w_byte = {phy_rxd, r_low_nib};

`ifdef MII_RX_FCS_CHECK_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    mii_crc32_byte u_crc (
        .i_crc  (r_crc),
        .i_data (w_byte),
        .o_crc  (w_crc_next)
    );

    // Reseeded in every non-DATA state so each frame starts from CRC_INIT.
    always_ff @(posedge phy_rx_clk) begin
        if (phy_rst || r_state != DATA) begin
            r_crc <= CRC_INIT;
        end else if (phy_rx_dv && r_phase) begin
            r_crc <= w_crc_next;
        end
    end

    assign w_crc_bad = (r_crc != CRC_RESIDUE);
`else
    assign w_crc_bad = 1'b0;
`endif

    always_comb begin
        w_state      = r_state;
        w_phase      = r_phase;
        w_low_nib    = r_low_nib;
        w_hold_data  = r_hold_data;
        w_hold_valid = r_hold_valid;
        w_byte_cnt   = r_byte_cnt;
        w_err        = r_err;
        w_m_data     = 8'h00;
        w_m_valid    = 1'b0;
        w_m_last     = 1'b0;
        w_m_err      = 1'b0;
        w_frame_len  = '0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        w_pre_err    = 1'b0;

        case (r_state)
            IDLE: begin
                if (phy_rx_dv && !r_dv_prev) begin
                    w_state = PRE;
                end
            end
            PRE: begin
                if (!phy_rx_dv) begin
                    w_state = IDLE;
                end else if (phy_rxd == SFD_NIB) begin
                    w_state      = DATA;
                    w_phase      = 1'b0;
                    w_hold_valid = 1'b0;
                    w_byte_cnt   = '0;
                    w_err        = 1'b0;
                end else if (phy_rxd != PREAMBLE_NIB) begin
                    w_state   = DROP;
                    w_pre_err = 1'b1;
                end
            end
            DATA: begin
                if (!phy_rx_dv) begin
                    // End of frame: the held byte becomes the last one.
                    w_state      = IDLE;
                    w_hold_valid = 1'b0;
                    if (r_hold_valid) begin
                        w_m_data    = r_hold_data;
                        w_m_valid   = 1'b1;
                        w_m_last    = 1'b1;
                        w_m_err     = r_err | r_phase | w_crc_bad;
                        w_frame_len = r_byte_cnt;
                        w_good      = !(r_err | r_phase | w_crc_bad);
                        w_bad       = r_err | r_phase | w_crc_bad;
                    end else begin
                        w_bad = 1'b1;
                    end
                end else begin
                    if (phy_rx_er) begin
                        w_err = 1'b1;
                    end
                    if (!r_phase) begin
                        w_low_nib = phy_rxd;
                        w_phase   = 1'b1;
                    end else begin
                        w_phase = 1'b0;
                        if (r_byte_cnt == c_max_cnt) begin
                            // Oversize: close the frame on the held byte, discard the new one.
                            w_state      = DROP;
                            w_hold_valid = 1'b0;
                            w_m_data     = r_hold_data;
                            w_m_valid    = r_hold_valid;
                            w_m_last     = r_hold_valid;
                            w_m_err      = r_hold_valid;
                            w_frame_len  = r_byte_cnt;
                            w_bad        = 1'b1;
                        end else begin
                            w_m_data     = r_hold_data;
                            w_m_valid    = r_hold_valid;
                            w_hold_data  = w_byte;
                            w_hold_valid = 1'b1;
                            if (r_byte_cnt != '1) begin
                                w_byte_cnt = r_byte_cnt + 1'b1;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (!phy_rx_dv) begin
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // dv history is tracked through reset so a frame in flight at reset release is never joined.
    always_ff @(posedge phy_rx_clk) begin
        r_dv_prev <= phy_rx_dv;
        if (phy_rst) begin
            r_state           <= IDLE;
            r_phase           <= 1'b0;
            r_low_nib         <= 4'h0;
            r_hold_data       <= 8'h00;
            r_hold_valid      <= 1'b0;
            r_byte_cnt        <= '0;
            r_err             <= 1'b0;
            m_data            <= 8'h00;
            m_valid           <= 1'b0;
            m_last            <= 1'b0;
            m_err             <= 1'b0;
            frame_len         <= '0;
            stat_frame_good   <= 1'b0;
            stat_frame_bad    <= 1'b0;
            stat_preamble_err <= 1'b0;
        end else begin
            r_state           <= w_state;
            r_phase           <= w_phase;
            r_low_nib         <= w_low_nib;
            r_hold_data       <= w_hold_data;
            r_hold_valid      <= w_hold_valid;
            r_byte_cnt        <= w_byte_cnt;
            r_err             <= w_err;
            m_data            <= w_m_data;
            m_valid           <= w_m_valid;
            m_last            <= w_m_last;
            m_err             <= w_m_err;
            frame_len         <= w_frame_len;
            stat_frame_good   <= w_good;
            stat_frame_bad    <= w_bad;
            stat_preamble_err <= w_pre_err;
        end
    end

endmodule
`default_nettype wire
